// File: rtl/saf_sample_sequencer.sv
// -----------------------------------------------------------------------------
// saf_sample_sequencer
//
// Run-time controller for the hybrid spline adaptive filter datapath. It sits
// between the sample source and the filter top and:
//   * optionally fills the spline control-point table with an identity ramp,
//   * accepts input/desired sample pairs and strobes each one into the
//     datapath for a single advance-enable cycle,
//   * tracks pipeline occupancy so out_valid marks outputs of real samples,
//   * gates weight adaptation (train for train_len samples, then freeze),
//   * flushes the pipeline with LAT zero samples when the session stops.
//
// Build option:
//   SAF_SEQ_QINIT_EN  defined   -> IDLE -> INIT (Q table writes) -> RUN
//                     undefined -> IDLE -> RUN directly; qinit_* tied to 0
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start / stop            one-cycle session control pulses
//   train_len               samples to adapt before freezing (0 = forever)
//   in_valid / in_ready     sample-source handshake
//   signal_in / desired_in  sample pair from the source
//   filt_signal/_desired    registered sample pair to the datapath
//   filt_en                 datapath advance (clock-gate) enable
//   adapt_en                weight update enable
//   qinit_we/_addr/_data    control-point table write port
//   out_valid               datapath output belongs to a real sample
//   busy / done             session active / one-cycle end-of-flush pulse
//   state_dbg               current FSM state (IDLE=0, INIT=1, RUN=2, FLUSH=3)
//
// Handshake: a sample transfers on every rising clk edge where in_valid and
// in_ready are both high; in_ready is registered and high for all of RUN, so
// the source may hold in_valid high and stream one sample per cycle. in_valid
// is not required to stay high without a transfer.
// -----------------------------------------------------------------------------
module saf_sample_sequencer #(
  parameter int WIDTH    = 16,
  parameter int QP       = 12,
  parameter int Q        = 13,
  parameter int DX_SHIFT = 2,
  parameter int LAT      = 6,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     train_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     signal_in,
  input  logic [WIDTH-1:0]     desired_in,
  output logic [WIDTH-1:0]     filt_signal,
  output logic [WIDTH-1:0]     filt_desired,
  output logic                 filt_en,
  output logic                 adapt_en,
  output logic                 qinit_we,
  output logic [$clog2(Q)-1:0] qinit_addr,
  output logic [WIDTH-1:0]     qinit_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int AW = $clog2(Q);
  localparam int FW = $clog2(LAT + 1);

  // The occupancy shift register needs at least two stages, the table at
  // least two entries, and the ramp shift must not be negative.
  if (LAT < 2 || Q < 2 || QP < DX_SHIFT) begin : g_cfg_check
    $error("saf_sample_sequencer: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   train_len_q, train_len_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic [WIDTH-1:0]   filt_signal_q, filt_signal_d;
  logic [WIDTH-1:0]   filt_desired_q, filt_desired_d;
  logic               filt_en_q, filt_en_d;
  logic               adapt_en_q, adapt_en_d;
  // Marks the current strobe as a real sample (vs. a flush zero).
  logic               real_q, real_d;
  logic [LAT-1:0]     shift_q, shift_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               handshake;

`ifdef SAF_SEQ_QINIT_EN
  logic               qinit_we_q, qinit_we_d;
  logic [AW-1:0]      qinit_addr_q, qinit_addr_d;
  logic [WIDTH-1:0]   qinit_data_q, qinit_data_d;

  localparam logic [AW-1:0] LAST_ADDR = AW'(Q - 1);

  // Identity ramp: entry i holds (i - centre) / DeltaX in QP fixed point,
  // i.e. (i - (Q-1)/2) shifted left by (QP - DX_SHIFT), truncated to WIDTH.
  function automatic logic [WIDTH-1:0] ramp_value(input logic [AW-1:0] idx);
    return WIDTH'((int'(idx) - (Q - 1) / 2) <<< (QP - DX_SHIFT));
  endfunction
`endif

  assign handshake = in_valid & in_ready_q;

  always_comb begin
    state_d        = state_q;
    train_len_d    = train_len_q;
    sample_cnt_d   = sample_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    in_ready_d     = in_ready_q;
    filt_signal_d  = filt_signal_q;
    filt_desired_d = filt_desired_q;
    filt_en_d      = 1'b0;
    adapt_en_d     = 1'b0;
    real_d         = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
`ifdef SAF_SEQ_QINIT_EN
    qinit_we_d     = 1'b0;
    qinit_addr_d   = '0;
    qinit_data_d   = '0;
`endif

    // Occupancy only moves when the datapath actually advances, so stalls
    // freeze it together with the datapath pipeline.
    shift_d = shift_q;
    if (filt_en_q) begin
      shift_d = {shift_q[LAT-2:0], real_q};
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          train_len_d  = train_len;
          sample_cnt_d = '0;
          busy_d       = 1'b1;
`ifdef SAF_SEQ_QINIT_EN
          state_d      = ST_INIT;
          qinit_we_d   = 1'b1;
          qinit_addr_d = '0;
          qinit_data_d = ramp_value('0);
`else
          state_d      = ST_RUN;
          in_ready_d   = 1'b1;
`endif
        end
      end

`ifdef SAF_SEQ_QINIT_EN
      ST_INIT: begin
        if (qinit_addr_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          in_ready_d = 1'b1;
        end else begin
          qinit_we_d   = 1'b1;
          qinit_addr_d = qinit_addr_q + AW'(1);
          qinit_data_d = ramp_value(qinit_addr_q + AW'(1));
        end
      end
`endif

      ST_RUN: begin
        // Evaluated with the count before this sample, so the flag travels
        // with the sample it is registered alongside.
        adapt_en_d = (train_len_q == '0) || (sample_cnt_q < train_len_q);
        if (handshake) begin
          filt_signal_d  = signal_in;
          filt_desired_d = desired_in;
          filt_en_d      = 1'b1;
          real_d         = 1'b1;
          if (sample_cnt_q != '1) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end
        // A sample accepted in the same cycle as stop is still strobed on
        // the next cycle; the zero fill starts after it.
        if (stop) begin
          state_d     = ST_FLUSH;
          in_ready_d  = 1'b0;
          flush_cnt_d = '0;
        end
      end

      ST_FLUSH: begin
        filt_signal_d  = '0;
        filt_desired_d = '0;
        filt_en_d      = 1'b1;
        flush_cnt_d    = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FW'(LAT - 1)) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      train_len_q    <= '0;
      sample_cnt_q   <= '0;
      flush_cnt_q    <= '0;
      in_ready_q     <= 1'b0;
      filt_signal_q  <= '0;
      filt_desired_q <= '0;
      filt_en_q      <= 1'b0;
      adapt_en_q     <= 1'b0;
      real_q         <= 1'b0;
      shift_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef SAF_SEQ_QINIT_EN
      qinit_we_q     <= 1'b0;
      qinit_addr_q   <= '0;
      qinit_data_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      train_len_q    <= train_len_d;
      sample_cnt_q   <= sample_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      in_ready_q     <= in_ready_d;
      filt_signal_q  <= filt_signal_d;
      filt_desired_q <= filt_desired_d;
      filt_en_q      <= filt_en_d;
      adapt_en_q     <= adapt_en_d;
      real_q         <= real_d;
      shift_q        <= shift_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef SAF_SEQ_QINIT_EN
      qinit_we_q     <= qinit_we_d;
      qinit_addr_q   <= qinit_addr_d;
      qinit_data_q   <= qinit_data_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign filt_signal  = filt_signal_q;
  assign filt_desired = filt_desired_q;
  assign filt_en      = filt_en_q;
  assign adapt_en     = adapt_en_q;
  // The top occupancy bit reaches the output stage exactly on the LAT-th
  // advance after the sample's own strobe.
  assign out_valid    = filt_en_q & shift_q[LAT-1];
  assign busy         = busy_q;
  assign done         = done_q;
  assign state_dbg    = state_q;

`ifdef SAF_SEQ_QINIT_EN
  assign qinit_we   = qinit_we_q;
  assign qinit_addr = qinit_addr_q;
  assign qinit_data = qinit_data_q;
`else
  assign qinit_we   = 1'b0;
  assign qinit_addr = '0;
  assign qinit_data = '0;
`endif

endmodule

// File: tb/tb_saf_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_saf_sample_sequencer
//
// Bench for saf_sample_sequencer. Inputs are driven 1 time unit after the
// rising edge; the monitor samples on the falling edge. Every accepted sample
// is pushed to exp_q and popped on its strobe; the enable index at which each
// sample's out_valid is due is pushed to ov_q.
// -----------------------------------------------------------------------------
module tb_saf_sample_sequencer;

  localparam int WIDTH    = 16;
  localparam int QP       = 12;
  localparam int Q        = 13;
  localparam int DX_SHIFT = 2;
  localparam int LAT      = 6;
  localparam int CNT_W    = 16;
  localparam int AW       = $clog2(Q);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] train_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] signal_in;
  logic [WIDTH-1:0] desired_in;
  logic [WIDTH-1:0] filt_signal;
  logic [WIDTH-1:0] filt_desired;
  logic             filt_en;
  logic             adapt_en;
  logic             qinit_we;
  logic [AW-1:0]    qinit_addr;
  logic [WIDTH-1:0] qinit_data;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  saf_sample_sequencer #(
    .WIDTH(WIDTH), .QP(QP), .Q(Q), .DX_SHIFT(DX_SHIFT), .LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .train_len(train_len), .in_valid(in_valid), .in_ready(in_ready),
    .signal_in(signal_in), .desired_in(desired_in),
    .filt_signal(filt_signal), .filt_desired(filt_desired),
    .filt_en(filt_en), .adapt_en(adapt_en),
    .qinit_we(qinit_we), .qinit_addr(qinit_addr), .qinit_data(qinit_data),
    .out_valid(out_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- model
  bit                 mon_en = 1'b0;
  bit                 hs_prev = 1'b0;
  logic [2*WIDTH:0]   exp_q[$];
  int                 ov_q[$];
  int                 en_cnt = 0;
  int                 ov_count = 0;
  int                 adapt_cnt = 0;
  int                 mon_cnt = 0;
  int                 first_ov_en = -1;
  int                 first_strobe_en = -1;
  logic [CNT_W-1:0]   mon_tl = '0;

  task automatic clear_model();
    hs_prev = 1'b0;
    exp_q.delete();
    ov_q.delete();
    en_cnt = 0;
    ov_count = 0;
    adapt_cnt = 0;
    mon_cnt = 0;
    first_ov_en = -1;
    first_strobe_en = -1;
  endtask

  // Scoreboard monitor: strobe contents and out_valid timing.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2*WIDTH:0] e;
      bit exp_ov;
      if (hs_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_queue_empty actual=strobe required=no_pending_sample");
        end else begin
          e = exp_q.pop_front();
          if (filt_en !== 1'b1 || {filt_signal, filt_desired, adapt_en} !== e) begin
            errors++;
            $display("FAIL strobe actual=en%b sig%h des%h ad%b required=en1 sig%h des%h ad%b",
                     filt_en, filt_signal, filt_desired, adapt_en,
                     e[2*WIDTH:WIDTH+1], e[WIDTH:1], e[0]);
          end
        end
        if (adapt_en === 1'b1) adapt_cnt++;
      end
      if (filt_en === 1'b1) en_cnt++;
      exp_ov = (filt_en === 1'b1) && (ov_q.size() > 0) && (ov_q[0] == en_cnt);
      if (exp_ov) void'(ov_q.pop_front());
      checks++;
      if (out_valid !== exp_ov) begin
        errors++;
        $display("FAIL out_valid en_idx=%0d actual=%b required=%b", en_cnt, out_valid, exp_ov);
      end
      if (out_valid === 1'b1) begin
        ov_count++;
        if (first_ov_en < 0) first_ov_en = en_cnt;
      end
      if (hs_prev && filt_en === 1'b1) begin
        ov_q.push_back(en_cnt + LAT);
        if (first_strobe_en < 0) first_strobe_en = en_cnt;
      end
      hs_prev = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (hs_prev) begin
        exp_q.push_back({signal_in, desired_in,
                         ((mon_tl == '0) || (CNT_W'(mon_cnt) < mon_tl)) ? 1'b1 : 1'b0});
        mon_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [CNT_W-1:0] tl);
    logic [31:0]      v32;
    logic [WIDTH-1:0] exp_data;
    logic [WIDTH-1:0] anchor;
    clear_model();
    mon_tl    = tl;
    start     = 1'b1;
    train_len = tl;
    tick();
    start     = 1'b0;
    train_len = CNT_W'($urandom_range(1, 65535));  // must already be latched
`ifdef SAF_SEQ_QINIT_EN
    for (int i = 0; i < Q; i++) begin
      v32 = 32'((i - (Q - 1) / 2) * (1 << (QP - DX_SHIFT)));
      exp_data = v32[WIDTH-1:0];
      checks++;
      if (qinit_we !== 1'b1 || qinit_addr !== AW'(i) || qinit_data !== exp_data ||
          in_ready !== 1'b0 || filt_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL init_write i=%0d actual=we%b a%0d d%h rdy%b en%b required=we1 a%0d d%h rdy0 en0",
                 i, qinit_we, qinit_addr, qinit_data, in_ready, filt_en, i, exp_data);
      end
      if (i == 0 || i == (Q - 1) / 2 || i == Q - 1) begin
        anchor = (i == 0) ? 16'hE800 : ((i == Q - 1) ? 16'h1800 : 16'h0000);
        checks++;
        if (qinit_data !== anchor) begin
          errors++;
          $display("FAIL init_anchor i=%0d actual=%h required=%h", i, qinit_data, anchor);
        end
      end
      tick();
    end
`endif
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || qinit_we !== 1'b0 || state_dbg !== 2'd2 ||
        filt_en !== 1'b0) begin
      errors++;
      $display("FAIL run_entry actual=rdy%b busy%b we%b st%0d en%b required=rdy1 busy1 we0 st2 en0",
               in_ready, busy, qinit_we, state_dbg, filt_en);
    end
  endtask

  // n samples, each followed by `gap` idle cycles.
  task automatic send(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL send_ready k=%0d actual=%b required=1", k, in_ready);
      end
      in_valid   = 1'b1;
      signal_in  = WIDTH'($urandom_range(0, 65535));
      desired_in = WIDTH'($urandom_range(0, 65535));
      tick();
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
        checks++;
        if (filt_en !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap k=%0d g=%0d actual=en%b ov%b required=en0 ov0", k, g, filt_en, out_valid);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic stop_flush(input bit with_sample, input int exp_ov);
    stop       = 1'b1;
    in_valid   = with_sample;
    signal_in  = WIDTH'($urandom_range(1, 65535));
    desired_in = WIDTH'($urandom_range(1, 65535));
    tick();
    stop     = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (filt_en !== with_sample || in_ready !== 1'b0 || busy !== 1'b1 || state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL stop_entry actual=en%b rdy%b busy%b st%0d required=en%b rdy0 busy1 st3",
               filt_en, in_ready, busy, state_dbg, with_sample);
    end
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (filt_en !== 1'b1 || filt_signal !== '0 || filt_desired !== '0 || adapt_en !== 1'b0 ||
          in_ready !== 1'b0 || done !== ((k == LAT) ? 1'b1 : 1'b0) ||
          busy !== ((k == LAT) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL flush k=%0d actual=en%b sig%h des%h ad%b rdy%b done%b busy%b required=en1 sig0 des0 ad0 rdy0 done%b busy%b",
                 k, filt_en, filt_signal, filt_desired, adapt_en, in_ready, done, busy,
                 (k == LAT), (k != LAT));
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || filt_en !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL post_flush actual=done%b en%b busy%b st%0d required=done0 en0 busy0 st0",
               done, filt_en, busy, state_dbg);
    end
    checks++;
    if (ov_count != exp_ov) begin
      errors++;
      $display("FAIL ov_count actual=%0d required=%0d", ov_count, exp_ov);
    end
    checks++;
    if (exp_q.size() != 0 || ov_q.size() != 0) begin
      errors++;
      $display("FAIL leftover actual=exp%0d ov%0d required=0 0", exp_q.size(), ov_q.size());
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    mon_en = 1'b0;
    clear_model();
    reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    train_len = '0; signal_in = '0; desired_in = '0;
    tick();
    tick();
    checks++;
    if ({in_ready, filt_signal, filt_desired, filt_en, adapt_en, qinit_we, qinit_addr,
         qinit_data, out_valid, busy, done, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual=rdy%b sig%h en%b we%b busy%b done%b st%0d required=all0",
               in_ready, filt_signal, filt_en, qinit_we, busy, done, state_dbg);
    end
    reset = 1'b0;
    stop  = 1'b1;  // ignored in IDLE
    tick();
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL idle_stop actual=busy%b rdy%b st%0d required=busy0 rdy0 st0", busy, in_ready, state_dbg);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_stream();
    start_session('0);
    send(10, 0);
    stop_flush(1'b0, 10);
    checks++;
    if (first_ov_en - first_strobe_en != LAT) begin
      errors++;
      $display("FAIL first_ov_latency actual=%0d required=%0d", first_ov_en - first_strobe_en, LAT);
    end
  endtask

  task automatic test_train();
    start_session(CNT_W'(4));
    send(8, 0);
    stop_flush(1'b0, 8);
    checks++;
    if (adapt_cnt != 4) begin
      errors++;
      $display("FAIL adapt_train4 actual=%0d required=4", adapt_cnt);
    end
    start_session('0);
    send(8, 0);
    stop_flush(1'b0, 8);
    checks++;
    if (adapt_cnt != 8) begin
      errors++;
      $display("FAIL adapt_forever actual=%0d required=8", adapt_cnt);
    end
  endtask

  task automatic test_gapped();
    start_session('0);
    send(4, 2);
    stop_flush(1'b0, 4);
  endtask

  task automatic test_stop_coincident();
    start_session('0);
    send(2, 1);
    stop_flush(1'b1, 3);
  endtask

  task automatic test_reset_mid();
    start     = 1'b1;
    train_len = '0;
    tick();
    start     = 1'b0;
`ifdef SAF_SEQ_QINIT_EN
    repeat (5) tick();
    checks++;
    if (qinit_we !== 1'b1 || qinit_addr !== AW'(5)) begin
      errors++;
      $display("FAIL reach_addr5 actual=we%b a%0d required=we1 a5", qinit_we, qinit_addr);
    end
`endif
    reset  = 1'b1;
    mon_en = 1'b0;
    clear_model();
    tick();
    checks++;
    if ({in_ready, filt_signal, filt_desired, filt_en, adapt_en, qinit_we, qinit_addr,
         qinit_data, out_valid, busy, done, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_mid_init actual=rdy%b we%b a%0d busy%b done%b st%0d required=all0",
               in_ready, qinit_we, qinit_addr, busy, done, state_dbg);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    start_session('0);  // init restarts from addr 0
    send(2, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    mon_en = 1'b0;
    clear_model();
    tick();
    checks++;
    if ({in_ready, filt_signal, filt_desired, filt_en, adapt_en, qinit_we, qinit_addr,
         qinit_data, out_valid, busy, done, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_mid_flush actual=rdy%b en%b busy%b done%b st%0d required=all0",
               in_ready, filt_en, busy, done, state_dbg);
    end
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || filt_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_reset k=%0d actual=done%b en%b busy%b required=0 0 0",
                 k, done, filt_en, busy);
      end
    end
    mon_en = 1'b1;
    start_session('0);
    send(3, 0);
    stop_flush(1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_train();
    test_gapped();
    test_stop_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
